// File: rtl/huffman_pkg.sv
// huffman_pkg: shared sizes, FSM state encoding and popcount helper for the Huffman decoder
package huffman_pkg;

    localparam int NSYM   = 6;
    localparam int CODE_W = 8;
    localparam int SYM_W  = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_EMIT = 2'd3
    } state_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        popcount8 = '0;
        for (int i = 0; i < 8; i++) popcount8 += {3'b000, v[i]};
    endfunction

endpackage

// File: rtl/huff_code_match.sv
// huff_code_match: combinational match of the shifted-in bits against the latched code table, lowest symbol wins
module huff_code_match
    import huffman_pkg::*;
(
    input  logic [CODE_W-1:0] acc_next,
    input  logic [3:0]        n,
    input  logic [CODE_W-1:0] hc [NSYM],
    input  logic [3:0]        len [NSYM],
    output logic              hit,
    output logic [SYM_W-1:0]  sym_idx
);

    logic [CODE_W-1:0] mask;

    assign mask = ~({CODE_W{1'b1}} << n);

    // scan downwards so a lower matching symbol overwrites any higher one
    always_comb begin
        hit     = 1'b0;
        sym_idx = '0;
        for (int k = NSYM - 1; k >= 0; k--) begin
            if (len[k] == n && ((acc_next ^ hc[k]) & mask) == '0) begin
                hit     = 1'b1;
                sym_idx = SYM_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/huffman_decoder.sv
// huffman_decoder: serial 6-symbol Huffman decoder; HUFF_DEC_CNT_EN adds per-symbol decode counters DCNT1..DCNT6
module huffman_decoder
    import huffman_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] HC1,
    input  logic [CODE_W-1:0] HC2,
    input  logic [CODE_W-1:0] HC3,
    input  logic [CODE_W-1:0] HC4,
    input  logic [CODE_W-1:0] HC5,
    input  logic [CODE_W-1:0] HC6,
    input  logic [CODE_W-1:0] M1,
    input  logic [CODE_W-1:0] M2,
    input  logic [CODE_W-1:0] M3,
    input  logic [CODE_W-1:0] M4,
    input  logic [CODE_W-1:0] M5,
    input  logic [CODE_W-1:0] M6,
    input  logic              flush,
    input  logic              bit_valid,
    input  logic              bit_data,
    output logic              bit_ready,
    output logic              sym_valid,
    output logic [SYM_W-1:0]  sym_data,
    input  logic              sym_ready,
    output logic              err
`ifdef HUFF_DEC_CNT_EN
    ,
    output logic [7:0]        DCNT1,
    output logic [7:0]        DCNT2,
    output logic [7:0]        DCNT3,
    output logic [7:0]        DCNT4,
    output logic [7:0]        DCNT5,
    output logic [7:0]        DCNT6
`endif
);

    state_t            state_q;
    logic [CODE_W-1:0] hc_q [NSYM];
    logic [CODE_W-1:0] m_q [NSYM];
    logic [3:0]        len_q [NSYM];
    logic [CODE_W-1:0] hc_in [NSYM];
    logic [CODE_W-1:0] m_in [NSYM];
    logic [CODE_W-1:0] acc_q, acc_d;
    logic [3:0]        nbits_q, nbits_d;
    logic              sym_valid_q, err_q;
    logic [SYM_W-1:0]  sym_data_q;
    logic              hit;
    logic [SYM_W-1:0]  sym_idx;

    assign hc_in = '{HC1, HC2, HC3, HC4, HC5, HC6};
    assign m_in  = '{M1, M2, M3, M4, M5, M6};

    // candidate accumulator state if the offered bit is taken
    assign acc_d   = {acc_q[CODE_W-2:0], bit_data};
    assign nbits_d = nbits_q + 4'd1;

    assign bit_ready = (state_q == S_RUN);
    assign sym_valid = sym_valid_q;
    assign sym_data  = sym_data_q;
    assign err       = err_q;

    huff_code_match u_match (
        .acc_next (acc_d),
        .n        (nbits_d),
        .hc       (hc_q),
        .len      (len_q),
        .hit      (hit),
        .sym_idx  (sym_idx)
    );

    // decoder FSM: table load, bit accumulation, symbol hand-off and overflow error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            nbits_q     <= '0;
            sym_valid_q <= 1'b0;
            sym_data_q  <= '0;
            err_q       <= 1'b0;
            for (int k = 0; k < NSYM; k++) begin
                hc_q[k]  <= '0;
                m_q[k]   <= '0;
                len_q[k] <= '0;
            end
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (code_valid) begin
                        hc_q    <= hc_in;
                        m_q     <= m_in;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    for (int k = 0; k < NSYM; k++) len_q[k] <= popcount8(m_q[k]);
                    state_q <= S_RUN;
                end
                S_RUN, S_EMIT: begin
                    if (flush) begin
                        acc_q       <= '0;
                        nbits_q     <= '0;
                        sym_valid_q <= 1'b0;
                        state_q     <= S_RUN;
                    end else if (state_q == S_EMIT) begin
                        if (sym_ready) begin
                            sym_valid_q <= 1'b0;
                            state_q     <= S_RUN;
                        end
                    end else if (bit_valid) begin
                        if (hit) begin
                            sym_data_q  <= sym_idx;
                            sym_valid_q <= 1'b1;
                            acc_q       <= '0;
                            nbits_q     <= '0;
                            state_q     <= S_EMIT;
                        end else if (nbits_d == 4'(CODE_W)) begin
                            err_q   <= 1'b1;
                            acc_q   <= '0;
                            nbits_q <= '0;
                        end else begin
                            acc_q   <= acc_d;
                            nbits_q <= nbits_d;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef HUFF_DEC_CNT_EN
    logic [7:0] cnt_q [NSYM];
    logic       accept;

    // a flush in the same cycle wins over sym_ready, so that symbol is not counted
    assign accept = (state_q == S_EMIT) && sym_valid_q && sym_ready && !flush;

    // per-symbol accepted-symbol counters, wrapping, untouched by flush
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NSYM; k++) cnt_q[k] <= '0;
        end else if (accept) begin
            for (int k = 0; k < NSYM; k++)
                if (sym_data_q == SYM_W'(k + 1)) cnt_q[k] <= cnt_q[k] + 8'd1;
        end
    end

    assign DCNT1 = cnt_q[0];
    assign DCNT2 = cnt_q[1];
    assign DCNT3 = cnt_q[2];
    assign DCNT4 = cnt_q[3];
    assign DCNT5 = cnt_q[4];
    assign DCNT6 = cnt_q[5];
`endif

endmodule
